// File: rtl/axis_test_pkg.sv
// Shared types and helpers for the AXI4-Stream test generators and checkers.
package axis_test_pkg;

  typedef enum logic [1:0] {IDLE, SYNC, CHECK} chk_state_t;

  // Feedback polynomial x^16 + x^14 + x^13 + x^11, MSB-first mask.
  localparam logic [15:0] LFSR16_TAPS = 16'hB400;

  // One Fibonacci step, shifting right: the feedback bit enters at bit 15,
  // taken from the state bits that mirror the tap mask (bits 0, 2, 3, 5).
  function automatic logic [15:0] lfsr16_step(input logic [15:0] s);
    logic fb;
    fb = 1'b0;
    for (int i = 0; i < 16; i++) begin
      if (LFSR16_TAPS[15-i]) fb = fb ^ s[i];
    end
    return {fb, s[15:1]};
  endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR that advances only while en is high.
module lfsr16
  import axis_test_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        aclk,
  input  logic        aresetn,
  input  logic        en,
  output logic [15:0] state
);

  // State register: load the seed on reset, step while enabled, else hold.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn)  state <= SEED;
    else if (en)   state <= lfsr16_step(state);
  end

endmodule

// File: rtl/s_axis_seq_checker.sv
// AXI4-Stream sink that checks an incrementing-count stream, counts beats and
// mismatches, captures the first bad value and optionally throttles tready.
module s_axis_seq_checker
  import axis_test_pkg::*;
#(
  parameter int          DATA_W    = 32,
  parameter int          ERR_W     = 16,
  parameter int          BP_ENABLE = 1,
  parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
  input  logic              aclk,
  input  logic              aresetn,
  input  logic [DATA_W-1:0] s_axis_tdata,
  input  logic              s_axis_tvalid,
  output logic              s_axis_tready,
  input  logic              enable,
  input  logic              clear,
  output logic              locked,
  output logic [31:0]       beat_count,
  output logic [ERR_W-1:0]  error_count,
  output logic [DATA_W-1:0] first_err_data,
  output logic              err_seen,
  output logic              error_pulse
);

  chk_state_t        state, state_next;
  logic [DATA_W-1:0] expected;
  logic [15:0]       lfsr, lfsr_next;
  logic              lfsr_unused;
  logic              tready_next;
  logic              accept;
  logic              mismatch;

  function automatic logic [ERR_W-1:0] sat_inc(input logic [ERR_W-1:0] v);
    return (&v) ? v : v + ERR_W'(1);
  endfunction

  lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .aclk    (aclk),
    .aresetn (aresetn),
    .en      (enable),
    .state   (lfsr)
  );

  assign accept      = s_axis_tvalid && s_axis_tready;
  assign mismatch    = (state == CHECK) && accept && (s_axis_tdata != expected);
  assign lfsr_unused = ^lfsr_next[15:2];

  // Next tready: the LFSR value that will be current next cycle gates it.
  always_comb begin
    lfsr_next   = enable ? lfsr16_step(lfsr) : lfsr;
    tready_next = enable && ((BP_ENABLE == 0) || (lfsr_next[1:0] != 2'b00));
  end

  // Next-state: a dropped tready means the source restarted, so resync.
  always_comb begin
    state_next = state;
    if (!enable) begin
      state_next = IDLE;
    end else begin
      case (state)
        IDLE:    state_next = SYNC;
        SYNC:    if (accept) state_next = CHECK;
        CHECK:   if (!s_axis_tready) state_next = SYNC;
        default: state_next = IDLE;
      endcase
    end
  end

  // State, tready and sequence tracking; any accepted beat sets the next
  // expected value, which covers sync, match and self-resync alike.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state         <= IDLE;
      s_axis_tready <= 1'b0;
      expected      <= '0;
      locked        <= 1'b0;
      error_pulse   <= 1'b0;
    end else begin
      state         <= state_next;
      s_axis_tready <= tready_next;
      error_pulse   <= mismatch;
      if (accept && (state != IDLE)) expected <= s_axis_tdata + DATA_W'(1);
      if (!enable || (state != CHECK))  locked <= 1'b0;
      else if (accept)                  locked <= !mismatch;
      else if (!s_axis_tready)          locked <= 1'b0;
    end
  end

  // Statistics: clear wins over a coincident beat or mismatch.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      beat_count     <= '0;
      error_count    <= '0;
      first_err_data <= '0;
      err_seen       <= 1'b0;
    end else if (clear) begin
      beat_count     <= '0;
      error_count    <= '0;
      first_err_data <= '0;
      err_seen       <= 1'b0;
    end else begin
      if (accept && (state != IDLE)) beat_count <= beat_count + 32'd1;
      if (mismatch) begin
        error_count <= sat_inc(error_count);
        if (!err_seen) begin
          first_err_data <= s_axis_tdata;
          err_seen       <= 1'b1;
        end
      end
    end
  end

endmodule

// File: doc/s_axis_seq_checker.md
Name: s_axis_seq_checker

Overview:
AXI4-Stream slave that consumes the incrementing-count test stream from the team's stream generators.
- Checks each accepted beat against the expected sequence.
- Counts beats and sequence errors, and captures the first offending value.
- Optionally applies pseudo-random backpressure on tready to exercise the transmitter's handshake.
- Sits at the sink end of loopback and FIFO/DMA test paths.

Parameters:
DATA_W, 32, width of s_axis_tdata and of the expected-value register
ERR_W, 16, width of error_count (saturating)
BP_ENABLE, 1, 1 = LFSR-gated tready, 0 = tready follows enable
LFSR_SEED, 16'hACE1, LFSR reset value (must be non-zero)

Ports:
aclk  in  1  clock, all logic on rising edge
aresetn  in  1  asynchronous active-low reset
s_axis_tdata  in  DATA_W  stream data
s_axis_tvalid  in  1  stream valid
s_axis_tready  out  1  stream ready (registered)
enable  in  1  checker enable; 0 holds tready low
clear  in  1  synchronous clear of beat_count, error_count, first_err_data, err_seen
locked  out  1  high while in CHECK and the last beat matched
beat_count  out  32  accepted beats, wraps modulo 2^32
error_count  out  ERR_W  mismatches, saturates at all-ones
first_err_data  out  DATA_W  tdata of first mismatch since reset/clear
err_seen  out  1  sticky, set on first mismatch
error_pulse  out  1  one-cycle pulse, registered, on each mismatch

Behaviour:
- Reset: aresetn is asynchronous, active-low; clock is aclk. On reset:
  - state = IDLE; tready, locked, error_pulse, err_seen = 0
  - beat_count, error_count, first_err_data, expected = 0; lfsr = LFSR_SEED
- Handshake: a beat is accepted when s_axis_tvalid && s_axis_tready at a rising edge. tdata is ignored when tvalid = 0.
- tready (registered, next-cycle):
  - BP_ENABLE = 0: tready <= enable.
  - BP_ENABLE = 1: tready <= enable && (lfsr_next[1:0] != 2'b00), giving about 75% duty.
  - LFSR: 16-bit Fibonacci, taps 16,14,13,11. Advances every cycle while enable = 1 and holds otherwise.
- The upstream generator restarts its sequence whenever tready drops. A cycle with tready = 0 therefore forces a resync, never an error.
- States:
  - IDLE: tready path inactive. Go to SYNC when enable = 1.
  - SYNC: on an accepted beat, expected <= tdata + 1 and go to CHECK; locked stays 0.
  - CHECK, accepted beat with tdata == expected: expected <= expected + 1, locked <= 1.
  - CHECK, accepted beat with tdata != expected: error_pulse <= 1, error_count++ (saturating), locked <= 0, expected <= tdata + 1 (self-resync, stay in CHECK). first_err_data and err_seen are loaded only if err_seen = 0.
  - CHECK, any cycle with registered tready = 0: go to SYNC, locked <= 0.
  - Any state, enable = 0: go to IDLE next cycle, locked <= 0. Counters are held, not cleared.
- Arithmetic:
  - expected wraps modulo 2^DATA_W, so all-ones followed by 0 is a match.
  - beat_count increments on every accepted beat in SYNC or CHECK.
- clear:
  - Has priority over a same-cycle increment: counts go to 0 and the coincident beat is not counted.
  - Does not affect state, expected or lfsr.
  - A same-cycle mismatch still pulses error_pulse but is not recorded.
- Latency: all status outputs update one cycle after the accepting edge.
- Reset mid-operation: everything returns to reset values immediately (asynchronous). tready is low until the first edge after release with enable = 1.

Decomposition:
- Package axis_test_pkg holds:
  - typedef enum logic [1:0] {IDLE, SYNC, CHECK} chk_state_t
  - localparam LFSR16_TAPS = 16'hB400
  - function lfsr16_step
- Sub-module lfsr16 (seed parameter, en input, 16-bit state output), shared with future stream generators.
- The checker FSM and counters stay in the top module.

Test Plan:
- BP_ENABLE=0, enable=1, source drives 1,2,3…1000 continuously:
  - locked=1 from the 2nd beat onward, beat_count=1000, error_count=0, err_seen=0.
- Inject 5,6,8,9: one error_pulse on the beat with 8.
  - error_count=1, first_err_data=8, locked drops for one beat.
  - Next beat (9) matches and locked returns to 1.
- Wrap: source drives 32'hFFFFFFFE, FFFFFFFF, 0, 1: error_count=0, beat_count=4.
- BP_ENABLE=1, generator restarts at 1 after each tready drop, 10000 cycles:
  - error_count=0.
  - tready-low fraction in 20–30%.
  - No beat accepted while tready=0.
- Force 70000 mismatches with ERR_W=16: error_count=16'hFFFF, err_seen=1, first_err_data = first bad value.
- Assert aresetn=0 mid-stream: outputs zero asynchronously. After release, the first beat resyncs with no error.
- clear pulse coincident with an accepted beat: beat_count=0 the following cycle.
